cte_stream: RTL and testbench

- Bidirectional colour-transform engine; parametrised, handshaked successor of the fixed 8-bit YUV-to-RGB converter in the CTE top.
- Mode 0: accepts a 4:2:2 byte stream (U, Y1, V, Y2) and emits two RGB pixels.
- Mode 1: accepts two RGB pixels and emits U, Y1, V, Y2.
- Output words are buffered in an internal FIFO under valid/ready flow control, so downstream stalls never drop data.

---
 rtl/cte_stream.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_cte_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cte_stream.sv
// cte_stream: bidirectional colour-transform engine (YUV 4:2:2 <-> RGB)
// with a valid/ready output FIFO that absorbs downstream stalls.
// Optional macro CTE_SAT_FLAG_EN adds a per-word saturation flag (sat_flag).
module cte_stream #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   yuv_in,
    input  logic [3*DW-1:0] rgb_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*DW-1:0] rgb_out,
    output logic [DW-1:0]   yuv_out,
`ifdef CTE_SAT_FLAG_EN
    output logic            sat_flag,
`endif
    output logic            busy
);

    localparam int SW = DW + 6;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef CTE_SAT_FLAG_EN
    localparam int FW = 3*DW + 1;
`else
    localparam int FW = 3*DW;
`endif

    localparam logic signed [SW-1:0] ZERO_K  = SW'(0);
    localparam logic signed [SW-1:0] ROUND_K = SW'(4);
    localparam logic signed [SW-1:0] MAXU_K  = SW'((1 << DW) - 1);
    localparam logic signed [SW-1:0] MAXS_K  = SW'((1 << (DW-1)) - 1);
    localparam logic signed [SW-1:0] MINS_K  = SW'(-(1 << (DW-1)));

    typedef enum logic [2:0] {
        IDLE, Y_Y1, Y_V, Y_Y2, R_U, R_Y1, R_V, R_P1
    } state_t;

    // Unsigned component widened to the signed sum width
    function automatic logic signed [SW-1:0] zx(input logic [DW-1:0] v);
        return signed'(SW'(v));
    endfunction

    // Two's-complement chroma widened to the signed sum width
    function automatic logic signed [SW-1:0] sx(input logic [DW-1:0] v);
        return SW'(signed'(v));
    endfunction

    // Divide by 8 with round-half-up
    function automatic logic signed [SW-1:0] rnd(input logic signed [SW-1:0] s);
        return (s + ROUND_K) >>> 3;
    endfunction

    function automatic logic [DW-1:0] clampU(input logic signed [SW-1:0] r);
        logic [DW-1:0] res;
        if (r < ZERO_K)      res = '0;
        else if (r > MAXU_K) res = '1;
        else                 res = r[DW-1:0];
        return res;
    endfunction

    function automatic logic [DW-1:0] clampS(input logic signed [SW-1:0] r);
        logic [DW-1:0] res;
        if (r < MINS_K)      res = MINS_K[DW-1:0];
        else if (r > MAXS_K) res = MAXS_K[DW-1:0];
        else                 res = r[DW-1:0];
        return res;
    endfunction

`ifdef CTE_SAT_FLAG_EN
    function automatic logic overU(input logic signed [SW-1:0] r);
        return (r < ZERO_K) || (r > MAXU_K);
    endfunction

    function automatic logic overS(input logic signed [SW-1:0] r);
        return (r < MINS_K) || (r > MAXS_K);
    endfunction
`endif

    state_t              state_q, state_d;
    logic [DW-1:0]       uLatch_q, uLatch_d;
    logic [DW-1:0]       y1Latch_q, y1Latch_d;
    logic [DW-1:0]       vLatch_q, vLatch_d;
    logic [3*DW-1:0]     pix0_q, pix0_d;

    logic [FW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wrPtr_q, rdPtr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       freeSlots;
    logic                accept, pushEn, popEn;

    logic [DW-1:0]       yOp, uOp, vOp;
    logic [3*DW-1:0]     pixOp;
    logic signed [SW-1:0] yE, uE, vE, rE, gE, bE;
    logic signed [SW-1:0] sumR, sumG, sumB, sumY, sumU, sumV;
    logic signed [SW-1:0] rndR, rndG, rndB, rndY, rndU, rndV;
    logic [3*DW-1:0]     pushData;
    logic [FW-1:0]       pushWord, headWord;

    assign freeSlots = CW'(DEPTH) - count_q;
    assign out_valid = (count_q != '0);
    assign popEn     = out_valid && out_ready;
    assign busy      = (state_q != IDLE) || out_valid;
    assign headWord  = mem_q[rdPtr_q];
    assign rgb_out   = headWord[3*DW-1:0];
    assign yuv_out   = headWord[DW-1:0];
`ifdef CTE_SAT_FLAG_EN
    assign sat_flag  = headWord[3*DW];
`endif

    // Group sequencer: handshake, component latching and push scheduling
    always_comb begin
        state_d   = state_q;
        uLatch_d  = uLatch_q;
        y1Latch_d = y1Latch_q;
        vLatch_d  = vLatch_q;
        pix0_d    = pix0_q;
        in_ready  = 1'b0;
        pushEn    = 1'b0;

        case (state_q)
            IDLE:                  in_ready = op_mode ? (freeSlots >= CW'(4))
                                                      : (freeSlots >= CW'(2));
            Y_Y1, Y_V, Y_Y2, R_P1: in_ready = 1'b1;
            default:               in_ready = 1'b0;
        endcase
        if (!reset) begin
            in_ready = 1'b0;
        end
        accept = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_mode) begin
                        pix0_d  = rgb_in;
                        state_d = R_U;
                    end else begin
                        uLatch_d = yuv_in;
                        state_d  = Y_Y1;
                    end
                end
            end
            Y_Y1: begin
                if (accept) begin
                    y1Latch_d = yuv_in;
                    state_d   = Y_V;
                end
            end
            Y_V: begin
                if (accept) begin
                    vLatch_d = yuv_in;
                    pushEn   = 1'b1;
                    state_d  = Y_Y2;
                end
            end
            Y_Y2: begin
                if (accept) begin
                    pushEn  = 1'b1;
                    state_d = IDLE;
                end
            end
            R_U: begin
                pushEn  = 1'b1;
                state_d = R_Y1;
            end
            R_Y1: begin
                pushEn  = 1'b1;
                state_d = R_V;
            end
            R_V: begin
                pushEn  = 1'b1;
                state_d = R_P1;
            end
            R_P1: begin
                if (accept) begin
                    pushEn  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand selection: Y_V converts with the V byte arriving this cycle
    always_comb begin
        yOp = yuv_in;
        uOp = uLatch_q;
        vOp = vLatch_q;
        if (state_q == Y_V) begin
            yOp = y1Latch_q;
            vOp = yuv_in;
        end
        pixOp = (state_q == R_P1) ? rgb_in : pix0_q;
    end

    assign yE = zx(yOp);
    assign uE = sx(uOp);
    assign vE = sx(vOp);
    assign rE = zx(pixOp[3*DW-1:2*DW]);
    assign gE = zx(pixOp[2*DW-1:DW]);
    assign bE = zx(pixOp[DW-1:0]);

    assign sumR = (yE <<< 3) + (vE <<< 3) + (vE <<< 2) + vE;
    assign sumG = (yE <<< 3) - (uE <<< 1) - (vE <<< 2) - (vE <<< 1);
    assign sumB = (yE <<< 3) + (uE <<< 4);
    assign sumY = (rE <<< 1) + (gE <<< 2) + gE + bE;
    assign sumU = (bE <<< 2) - rE - (gE <<< 1) - gE;
    assign sumV = (rE <<< 2) - (gE <<< 1) - gE - bE;

    assign rndR = rnd(sumR);
    assign rndG = rnd(sumG);
    assign rndB = rnd(sumB);
    assign rndY = rnd(sumY);
    assign rndU = rnd(sumU);
    assign rndV = rnd(sumV);

    // Word to push: an RGB pixel in mode 0, one clamped component in mode 1
    always_comb begin
        pushData = {clampU(rndR), clampU(rndG), clampU(rndB)};
        case (state_q)
            R_U:        pushData = {{(2*DW){1'b0}}, clampS(rndU)};
            R_Y1, R_P1: pushData = {{(2*DW){1'b0}}, clampU(rndY)};
            R_V:        pushData = {{(2*DW){1'b0}}, clampS(rndV)};
            default:    ;
        endcase
    end

`ifdef CTE_SAT_FLAG_EN
    logic pushSat;

    // Saturation marker travelling with the pushed word
    always_comb begin
        pushSat = overU(rndR) | overU(rndG) | overU(rndB);
        case (state_q)
            R_U:        pushSat = overS(rndU);
            R_Y1, R_P1: pushSat = overU(rndY);
            R_V:        pushSat = overS(rndV);
            default:    ;
        endcase
    end

    assign pushWord = {pushSat, pushData};
`else
    assign pushWord = pushData;
`endif

    // State, latches and FIFO storage with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            uLatch_q  <= '0;
            y1Latch_q <= '0;
            vLatch_q  <= '0;
            pix0_q    <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            uLatch_q  <= uLatch_d;
            y1Latch_q <= y1Latch_d;
            vLatch_q  <= vLatch_d;
            pix0_q    <= pix0_d;
            if (pushEn) begin
                mem_q[wrPtr_q] <= pushWord;
                wrPtr_q        <= wrPtr_q + AW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({pushEn, popEn})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cte_stream.sv
// tb_cte_stream: directed self-checking bench for cte_stream (DW=8, DEPTH=4).
`timescale 1ns/1ps
module tb_cte_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            op_mode;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   yuv_in;
    logic [3*DW-1:0] rgb_in;
    logic            out_valid;
    logic            out_ready;
    logic [3*DW-1:0] rgb_out;
    logic [DW-1:0]   yuv_out;
    logic            busy;
`ifdef CTE_SAT_FLAG_EN
    logic            sat_flag;
    logic            gotSat[$];
    logic            lastSat;
`endif

    int checks = 0;
    int errors = 0;
    logic [3*DW-1:0] gotRgb[$];
    logic [DW-1:0]   gotYuv[$];

    cte_stream #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_mode   (op_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .yuv_in    (yuv_in),
        .rgb_in    (rgb_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rgb_out   (rgb_out),
        .yuv_out   (yuv_out),
`ifdef CTE_SAT_FLAG_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every head word that pops on the coming rising edge
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            gotRgb.push_back(rgb_out);
            gotYuv.push_back(yuv_out);
`ifdef CTE_SAT_FLAG_EN
            gotSat.push_back(sat_flag);
`endif
        end
    end

    // Last-resort guard so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offer one input word and hold it until it is accepted
    task automatic applyStimulus(input logic [DW-1:0] b, input logic [3*DW-1:0] p);
        int k = 0;
        yuv_in   = b;
        rgb_in   = p;
        in_valid = 1'b1;
        #1;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (in_ready) tick();
        else checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic waitWords(input string tag, input int n);
        int k = 0;
        while (gotRgb.size() < n && k < 100) begin
            tick();
            k++;
        end
        checkOutput(tag, 32'(gotRgb.size()), 32'(n));
    endtask

    task automatic expectWord(input string tag, input logic isRgb,
                              input logic [31:0] expected);
        logic [3*DW-1:0] rw;
        logic [DW-1:0]   yw;
        logic [31:0]     obs;
        if (gotRgb.size() == 0) begin
            obs = 32'hDEADBEEF;
        end else begin
            rw  = gotRgb.pop_front();
            yw  = gotYuv.pop_front();
            obs = isRgb ? 32'(rw) : 32'(yw);
`ifdef CTE_SAT_FLAG_EN
            lastSat = gotSat.pop_front();
`endif
        end
        checkOutput(tag, obs, expected);
    endtask

    initial begin
        reset     = 1'b0;
        op_mode   = 1'b0;
        in_valid  = 1'b0;
        yuv_in    = '0;
        rgb_in    = '0;
        out_ready = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_rgb_out",   32'(rgb_out),   32'd0);
        checkOutput("rst_yuv_out",   32'(yuv_out),   32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
`ifdef CTE_SAT_FLAG_EN
        checkOutput("rst_sat_flag",  32'(sat_flag),  32'd0);
`endif
        reset = 1'b1;
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] grey YUV->RGB with stall");
        out_ready = 1'b1;
        op_mode   = 1'b0;
        applyStimulus(8'h00, '0);
        tick();
        tick();
        checkOutput("t1_stall_busy",      32'(busy),      32'd1);
        checkOutput("t1_stall_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(8'h64, '0);
        applyStimulus(8'h00, '0);
        checkOutput("t1_latency_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_latency_head",  32'(rgb_out),   32'h646464);
        applyStimulus(8'hC8, '0);
        waitWords("t1_count", 2);
        expectWord("t1_w0", 1'b1, 32'h646464);
`ifdef CTE_SAT_FLAG_EN
        checkOutput("t1_s0", 32'(lastSat), 32'd0);
`endif
        expectWord("t1_w1", 1'b1, 32'hC8C8C8);
        checkOutput("t1_busy_idle", 32'(busy), 32'd0);

        $display("[TB] saturating YUV->RGB");
        applyStimulus(8'h7F, '0);
        applyStimulus(8'hFF, '0);
        applyStimulus(8'h7F, '0);
        applyStimulus(8'h00, '0);
        waitWords("t2_count", 2);
        expectWord("t2_w0", 1'b1, 32'hFF80FF);
`ifdef CTE_SAT_FLAG_EN
        checkOutput("t2_s0", 32'(lastSat), 32'd1);
`endif
        expectWord("t2_w1", 1'b1, 32'hCE00FE);
`ifdef CTE_SAT_FLAG_EN
        checkOutput("t2_s1", 32'(lastSat), 32'd1);
`endif

        $display("[TB] RGB->YUV");
        op_mode = 1'b1;
        applyStimulus('0, 24'hFF0000);
        rgb_in   = 24'h00FF00;
        in_valid = 1'b1;
        #1;
        checkOutput("t3_ready_R_U", 32'(in_ready), 32'd0);
        tick();
        checkOutput("t3_ready_R_Y1", 32'(in_ready), 32'd0);
        tick();
        checkOutput("t3_ready_R_V", 32'(in_ready), 32'd0);
        tick();
        checkOutput("t3_ready_R_P1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        waitWords("t3_count", 4);
        expectWord("t3_u",  1'b0, 32'hE0);
`ifdef CTE_SAT_FLAG_EN
        checkOutput("t3_su", 32'(lastSat), 32'd0);
`endif
        expectWord("t3_y1", 1'b0, 32'h40);
        expectWord("t3_v",  1'b0, 32'h7F);
`ifdef CTE_SAT_FLAG_EN
        checkOutput("t3_sv", 32'(lastSat), 32'd1);
`endif
        expectWord("t3_y2", 1'b0, 32'h9F);

        $display("[TB] back-pressure with full FIFO");
        out_ready = 1'b0;
        op_mode   = 1'b0;
        applyStimulus(8'h00, '0);
        applyStimulus(8'h64, '0);
        applyStimulus(8'h00, '0);
        applyStimulus(8'hC8, '0);
        applyStimulus(8'h00, '0);
        applyStimulus(8'h32, '0);
        applyStimulus(8'h00, '0);
        applyStimulus(8'hFF, '0);
        checkOutput("t4_full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t4_full_busy",     32'(busy),     32'd1);
        checkOutput("t4_head",          32'(rgb_out),  32'h646464);
        yuv_in   = 8'h00;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("t4_hold_in_ready", 32'(in_ready),  32'd0);
        checkOutput("t4_head_stable",   32'(rgb_out),   32'h646464);
        checkOutput("t4_out_valid",     32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitWords("t4_count", 4);
        expectWord("t4_w0", 1'b1, 32'h646464);
        expectWord("t4_w1", 1'b1, 32'hC8C8C8);
        expectWord("t4_w2", 1'b1, 32'h323232);
        expectWord("t4_w3", 1'b1, 32'hFFFFFF);
        checkOutput("t4_busy_drained", 32'(busy), 32'd0);

        $display("[TB] mode change mid-group");
        op_mode = 1'b0;
        applyStimulus(8'h00, '0);
        op_mode = 1'b1;
        applyStimulus(8'h64, '0);
        applyStimulus(8'h00, '0);
        applyStimulus(8'h64, '0);
        waitWords("t5_count_rgb", 2);
        expectWord("t5_w0", 1'b1, 32'h646464);
        expectWord("t5_w1", 1'b1, 32'h646464);
        applyStimulus('0, 24'hFF0000);
        applyStimulus('0, 24'h00FF00);
        waitWords("t5_count_yuv", 4);
        expectWord("t5_u",  1'b0, 32'hE0);
        expectWord("t5_y1", 1'b0, 32'h40);
        expectWord("t5_v",  1'b0, 32'h7F);
        expectWord("t5_y2", 1'b0, 32'h9F);

        $display("[TB] reset mid-group");
        out_ready = 1'b0;
        op_mode   = 1'b0;
        applyStimulus(8'h00, '0);
        applyStimulus(8'h64, '0);
        applyStimulus(8'h00, '0);
        checkOutput("t6_one_queued", 32'(out_valid), 32'd1);
        reset = 1'b0;
        tick();
        checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rst_busy",      32'(busy),      32'd0);
        checkOutput("t6_rst_rgb_out",   32'(rgb_out),   32'd0);
        checkOutput("t6_rst_in_ready",  32'(in_ready),  32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(8'h00, '0);
        applyStimulus(8'h64, '0);
        applyStimulus(8'h00, '0);
        applyStimulus(8'h64, '0);
        waitWords("t6_count", 2);
        expectWord("t6_w0", 1'b1, 32'h646464);
        expectWord("t6_w1", 1'b1, 32'h646464);
        checkOutput("t6_busy_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
